// File: rtl/fir_direct_pipeline.sv
// fir_direct_pipeline
//   Pipelined direct-form FIR filter. A NUM_TAPS-deep sample delay line feeds
//   one registered multiplier per tap. The products are summed by a fully
//   registered binary adder tree, then scaled back to sample format with
//   saturation. One sample is accepted and one result is produced per clock.
//   There is no handshake.
//
//   Latency: a sample taken at edge t appears in out after edge t + D + 2,
//   where D = ceil(log2(NUM_TAPS)).
//
// Parameters
//   DATA_WIDTH      signed sample width (input and output)
//   TAP_COEFF_WIDTH signed coefficient width, Q1.(TAP_COEFF_WIDTH-1)
//   NUM_TAPS        filter length (>= 1)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset; clears all pipeline state
//   in          input sample, taken every rising edge
//   out         registered, saturated filter output
//   tap_coeffs  tap_coeffs[k] weights the sample delayed by k
//               (read combinationally at the product stage)
//   mult_out    (DEBUG_MULT_OUT_EN only) per-tap product scaled to sample
//               format; wraps rather than saturates
//
// Optional feature macro: DEBUG_MULT_OUT_EN
module fir_direct_pipeline #(
  parameter int unsigned DATA_WIDTH      = 5,
  parameter int unsigned TAP_COEFF_WIDTH = 5,
  parameter int unsigned NUM_TAPS        = 50
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [DATA_WIDTH-1:0]      in,
  input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
  output logic signed [DATA_WIDTH-1:0]      out
`ifdef DEBUG_MULT_OUT_EN
  ,
  output logic signed [DATA_WIDTH-1:0]      mult_out [NUM_TAPS]
`endif
);

  localparam int unsigned PROD_W = DATA_WIDTH + TAP_COEFF_WIDTH;
  localparam int unsigned D      = $clog2(NUM_TAPS);
  localparam int unsigned SUM_W  = PROD_W + D;
  localparam int unsigned SHIFT  = TAP_COEFF_WIDTH - 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((32'd1 << (DATA_WIDTH - 1)) - 32'd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  // Number of nodes at adder-tree level lv (level 0 = products).
  function automatic int unsigned lvl_cnt(input int unsigned lv);
    return (NUM_TAPS + (32'd1 << lv) - 32'd1) >> lv;
  endfunction

  // Sample delay line
  logic signed [DATA_WIDTH-1:0] r_x [NUM_TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) r_x[k] <= '0;
    end else begin
      r_x[0] <= in;
      for (int unsigned k = 1; k < NUM_TAPS; k++) r_x[k] <= r_x[k-1];
    end
  end

  // Level 0 holds the registered products; each further level halves the
  // node count and widens by one bit, so no level can overflow.
  for (genvar lv = 0; lv <= D; lv++) begin : g_lvl
    localparam int unsigned CNT = lvl_cnt(lv);
    localparam int unsigned W   = PROD_W + lv;

    logic signed [W-1:0] r_sum [CNT];

    if (lv == 0) begin : g_mul
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned k = 0; k < CNT; k++) r_sum[k] <= '0;
        end else begin
          for (int unsigned k = 0; k < CNT; k++)
            r_sum[k] <= W'(tap_coeffs[k]) * W'(r_x[k]);
        end
      end
    end else begin : g_add
      localparam int unsigned PCNT = lvl_cnt(lv - 1);

      // Previous level zero-padded to an even count: an odd trailing node is
      // summed with zero, which is the same as registering it unchanged.
      logic signed [W-1:0] w_pad [2*CNT];

      always_comb begin
        w_pad = '{default: '0};
        for (int unsigned j = 0; j < PCNT; j++)
          w_pad[j] = W'(g_lvl[lv-1].r_sum[j]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < CNT; i++) r_sum[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < CNT; i++)
            r_sum[i] <= w_pad[2*i] + w_pad[2*i+1];
        end
      end
    end
  end

  // Output scaling: arithmetic shift floors, then clamp to the sample range.
  logic signed [SUM_W-1:0]      w_shift;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] r_out;

  assign w_shift = g_lvl[D].r_sum[0] >>> SHIFT;

  always_comb begin
    w_sat = w_shift[DATA_WIDTH-1:0];
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_out <= '0;
    else     r_out <= w_sat;
  end

  assign out = r_out;

`ifdef DEBUG_MULT_OUT_EN
  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++)
      mult_out[k] = DATA_WIDTH'(g_lvl[0].r_sum[k] >>> SHIFT);
  end
`endif

endmodule

// File: tb/tb_fir_direct_pipeline.sv
// Scoreboard bench for fir_direct_pipeline (NUM_TAPS=50, L=8).
// The stimulus process issues one sample per cycle and queues the value out
// must show L edges later; the monitor pops and compares each cycle.
module tb_fir_direct_pipeline;

  localparam int NT = 50;
  localparam int L  = 8;
  localparam int SH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [4:0] din = '0;
  logic signed [4:0] dout;
  logic signed [4:0] coeffs [NT];

  fir_direct_pipeline #(
    .DATA_WIDTH      (5),
    .TAP_COEFF_WIDTH (5),
    .NUM_TAPS        (NT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .tap_coeffs (coeffs),
    .out        (dout)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct {
    int    tgt;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int   hist [NT];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;
  int   deadline = 0;
  exp_t mon_e;

  function automatic int model();
    int acc;
    acc = 0;
    for (int k = 0; k < NT; k++) acc += int'(coeffs[k]) * hist[k];
    acc = acc >>> SH;
    if (acc > 15)  acc = 15;
    if (acc < -16) acc = -16;
    return acc;
  endfunction

  task automatic set_coeffs(input int val, input int n);
    for (int k = 0; k < NT; k++) coeffs[k] = (k < n) ? 5'(val) : 5'sd0;
  endtask

  // Drive one cycle. A reset edge r forces out=0 for edges r..r+L, so every
  // pending expectation in that window is rewritten to 0.
  task automatic issue(input int v, input bit r, input bit hand, input int hexp,
                       input string nm);
    exp_t e;
    int   nxt;
    @(negedge clk);
    din = 5'(v);
    rst = r;
    e.tgt = ecnt + 1 + L;
    e.nm  = nm;
    if (r) begin
      for (int k = 0; k < NT; k++) hist[k] = 0;
      foreach (q[j]) if (q[j].tgt >= ecnt + 1) begin
        q[j].val = 0;
        q[j].nm  = nm;
      end
      nxt = (q.size() > 0) ? q[$].tgt + 1 : ecnt + 1;
      for (int t = nxt; t <= ecnt + L; t++) begin
        exp_t f;
        f.tgt = t; f.val = 0; f.nm = nm;
        q.push_back(f);
      end
      e.val = 0;
    end else begin
      for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(din);
      e.val = hand ? hexp : model();
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt <= ecnt) begin
      mon_e = q.pop_front();
      checks++;
      if (int'(dout) != mon_e.val) begin
        errors++;
        $display("FAIL %s edge %0d: out=%0d expected %0d", mon_e.nm, ecnt,
                 int'(dout), mon_e.val);
      end
    end
    if (stim_done) begin
      if (q.size() == 0) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else if (ecnt > deadline) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", q.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int step_exp [8];
    int rv;
    step_exp = '{1, 3, 4, 6, 6, 6, 6, 6};
    for (int k = 0; k < NT; k++) hist[k] = 0;
    set_coeffs(3, 4);

    // Power-up reset with toggling input
    issue(15, 1'b1, 1'b0, 0, "reset");
    issue(-16, 1'b1, 1'b0, 0, "reset");

    // Some history, then a 2-cycle mid-stream reset with toggling input
    repeat (10) issue(7, 1'b0, 1'b0, 0, "warm");
    issue(15, 1'b1, 1'b0, 0, "reset2");
    issue(-16, 1'b1, 1'b0, 0, "reset2");
    repeat (12) issue(15, 1'b0, 1'b0, 0, "release");

    // Impulse: 45>>>4 = 2 for four cycles
    issue(0, 1'b1, 1'b0, 0, "imp_rst");
    issue(0, 1'b1, 1'b0, 0, "imp_rst");
    repeat (4) issue(0, 1'b0, 1'b1, 0, "impulse");
    issue(15, 1'b0, 1'b1, 2, "impulse");
    repeat (3) issue(0, 1'b0, 1'b1, 2, "impulse");
    repeat (6) issue(0, 1'b0, 1'b1, 0, "impulse");

    // Step of 8: 1,3,4,6 then hold; then one-cycle reset and zeros
    for (int i = 0; i < 8; i++) issue(8, 1'b0, 1'b1, step_exp[i], "step");
    issue(8, 1'b1, 1'b0, 0, "midrst");
    repeat (10) issue(0, 1'b0, 1'b1, 0, "midrst");

    // Saturation: all taps 15. Positive clamp, then after switching to -16
    // the sum stays >= 15 until 24 negatives (5), then clamps to -16.
    set_coeffs(15, NT);
    issue(0, 1'b1, 1'b0, 0, "sat_rst");
    issue(0, 1'b1, 1'b0, 0, "sat_rst");
    for (int i = 0; i < 60; i++) issue(15, 1'b0, 1'b1, (i == 0) ? 14 : 15, "sat_pos");
    for (int b = 1; b <= 40; b++)
      issue(-16, 1'b0, 1'b1, (b <= 23) ? 15 : ((b == 24) ? 5 : -16), "sat_neg");

    // Ramp from -1 wrapping 15 -> -16, checked against the reference model
    set_coeffs(3, 4);
    issue(0, 1'b1, 1'b0, 0, "ramp_rst");
    issue(0, 1'b1, 1'b0, 0, "ramp_rst");
    rv = -1;
    for (int i = 0; i < 40; i++) begin
      issue(rv, 1'b0, 1'b0, 0, "ramp");
      rv = (rv == 15) ? -16 : rv + 1;
    end

    repeat (12) issue(0, 1'b0, 1'b0, 0, "flush");
    deadline  = ecnt + 4 * L;
    stim_done = 1'b1;
  end

endmodule
